// File: rtl/sram_bridge_pkg.sv
// Shared types and elaboration-time helpers for the wait-stated SRAM bridge.
package sram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    WR_ACC,
    WR_REC,
    DONE
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchroniser; presets to 1 so an idle (high) strobe is seen during reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ff <= '1;
    else       r_ff <= {r_ff[STAGES-2:0], i_d};
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/sram_bridge_ws.sv
// ARM static-memory to asynchronous SRAM bridge with programmable read/write
// wait states. The ARM is held off with ARM_NWAIT until the SRAM access completes.
module sram_bridge_ws
  import sram_bridge_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 19,
  parameter int unsigned RD_WS       = 2,
  parameter int unsigned WR_WS       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  inout  wire logic [DW-1:0] ARM_D,
  input  logic [AW-1:0] ARM_A,
  input  logic          ARM_CS,
  input  logic          ARM_OE,
  input  logic          ARM_WE,
  output logic          ARM_NWAIT,
  inout  wire logic [DW-1:0] SRAM_D,
  output logic [AW-1:0] SRAM_A,
  output logic          SRAM_CS,
  output logic          SRAM_OE,
  output logic          SRAM_WE
);

  localparam int unsigned WS_MAX = max2(RD_WS, WR_WS);
  localparam int unsigned CW_RAW = clog2(WS_MAX + 1);
  localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_WS);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_WS);

  logic          w_cs_s;
  logic          w_oe_s;
  logic          w_we_s;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic          w_cs_n_nxt;
  logic          w_oe_n_nxt;
  logic          w_we_n_nxt;
  logic          w_drv_nxt;

  logic          r_sram_cs;
  logic          r_sram_oe;
  logic          r_sram_we;
  logic          r_drv;
  logic [AW-1:0] r_sram_a;
  logic [DW-1:0] r_rd_q;
  logic [DW-1:0] r_wr_q;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (ARM_CS),
    .o_q   (w_cs_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_oe (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (ARM_OE),
    .o_q   (w_oe_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_we (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (ARM_WE),
    .o_q   (w_we_s)
  );

  // State and wait-state counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; an abort (CS high) is only observed once back in DONE,
  // so a started SRAM pulse always runs to full length.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (!w_cs_s) begin
          // OE wins over WE, so a simultaneous OE/WE request becomes a read.
          if (!w_oe_s) begin
            w_state_nxt = RD_ACC;
            w_cnt_nxt   = '0;
          end else if (!w_we_s) begin
            w_state_nxt = WR_ACC;
            w_cnt_nxt   = '0;
          end
        end
      end
      RD_ACC: begin
        if (r_cnt == RD_LAST) w_state_nxt = DONE;
        else                  w_cnt_nxt   = r_cnt + CW'(1);
      end
      WR_ACC: begin
        if (r_cnt == WR_LAST) w_state_nxt = WR_REC;
        else                  w_cnt_nxt   = r_cnt + CW'(1);
      end
      WR_REC: w_state_nxt = DONE;
      DONE: begin
        if (w_cs_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // SRAM strobe values for the upcoming state; registered below so the pins are glitch-free.
  always_comb begin
    w_cs_n_nxt = 1'b1;
    w_oe_n_nxt = 1'b1;
    w_we_n_nxt = 1'b1;
    w_drv_nxt  = 1'b0;
    unique case (w_state_nxt)
      RD_ACC: begin
        w_cs_n_nxt = 1'b0;
        w_oe_n_nxt = 1'b0;
      end
      WR_ACC: begin
        w_cs_n_nxt = 1'b0;
        w_we_n_nxt = 1'b0;
        w_drv_nxt  = 1'b1;
      end
      WR_REC: begin
        w_cs_n_nxt = 1'b0;
        w_drv_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered SRAM pins, address/data capture on access start, read data capture on last cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sram_cs <= 1'b1;
      r_sram_oe <= 1'b1;
      r_sram_we <= 1'b1;
      r_drv     <= 1'b0;
      r_sram_a  <= '0;
      r_rd_q    <= '0;
      r_wr_q    <= '0;
    end else begin
      r_sram_cs <= w_cs_n_nxt;
      r_sram_oe <= w_oe_n_nxt;
      r_sram_we <= w_we_n_nxt;
      r_drv     <= w_drv_nxt;
      if (r_state == IDLE && w_state_nxt != IDLE) r_sram_a <= ARM_A;
      if (r_state == IDLE && w_state_nxt == WR_ACC) r_wr_q <= ARM_D;
      if (r_state == RD_ACC && r_cnt == RD_LAST) r_rd_q <= SRAM_D;
    end
  end

  assign SRAM_CS = r_sram_cs;
  assign SRAM_OE = r_sram_oe;
  assign SRAM_WE = r_sram_we;
  assign SRAM_A  = r_sram_a;
  assign SRAM_D  = r_drv ? r_wr_q : 'z;

  // Raw pins are used here so the ARM sees the wait request within pad delay.
  assign ARM_NWAIT = RST | ARM_CS | (r_state == DONE);
  assign ARM_D     = (!RST && !ARM_CS && !ARM_OE) ? r_rd_q : 'z;

endmodule

// File: tb/tb_sram_bridge_ws.sv
// Bench for sram_bridge_ws: four bridges with different wait-state settings,
// each with its own SRAM model, sharing one ARM-side bus.
module tb_sram_bridge_ws;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int MEMD = 524288;

  function automatic int rdw(input int k);
    case (k)
      0: return 2;
      1: return 0;
      2: return 1;
      default: return 5;
    endcase
  endfunction

  function automatic int wrw(input int k);
    case (k)
      0: return 0;
      1: return 1;
      2: return 5;
      default: return 3;
    endcase
  endfunction

  // Background contents of never-written SRAM locations.
  function automatic logic [7:0] bg(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'hC2;
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [18:0]   arm_a;
  logic          arm_oe;
  logic          arm_we;
  logic [N-1:0]  arm_cs;
  logic          arm_drv;
  logic [7:0]    arm_dout;
  wire  [7:0]    arm_d;

  wire  [N-1:0]    nwait;
  wire  [N-1:0]    s_cs;
  wire  [N-1:0]    s_oe;
  wire  [N-1:0]    s_we;
  wire  [N*19-1:0] s_a_all;
  wire  [N*8-1:0]  sd_all;

  logic [7:0] mem [N][MEMD];
  bit         wf  [N][MEMD];

  assign arm_d = arm_drv ? arm_dout : 8'bz;
  pullup (arm_d);

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    wire [7:0] sd;
    pullup (sd);
    assign sd = (!s_cs[g] && !s_oe[g]) ?
                (wf[g][s_a_all[g*19 +: 19]] ? mem[g][s_a_all[g*19 +: 19]] : bg(s_a_all[g*19 +: 19])) :
                8'bz;
    assign sd_all[g*8 +: 8] = sd;

    sram_bridge_ws #(
      .DW          (8),
      .AW          (19),
      .RD_WS       (rdw(g)),
      .WR_WS       (wrw(g)),
      .SYNC_STAGES (SYNC)
    ) u_dut (
      .CLK       (clk),
      .RST       (rst),
      .ARM_D     (arm_d),
      .ARM_A     (arm_a),
      .ARM_CS    (arm_cs[g]),
      .ARM_OE    (arm_oe),
      .ARM_WE    (arm_we),
      .ARM_NWAIT (nwait[g]),
      .SRAM_D    (sd),
      .SRAM_A    (s_a_all[g*19 +: 19]),
      .SRAM_CS   (s_cs[g]),
      .SRAM_OE   (s_oe[g]),
      .SRAM_WE   (s_we[g])
    );
  end

  // Pulse-width monitor and SRAM write capture (SRAM latches on WE rising, CS low).
  int         oe_run[N];
  int         we_run[N];
  int         n_oe[N];
  int         n_we[N];
  int         last_oe_w[N];
  int         last_we_w[N];
  logic [7:0] hold_d[N];
  logic       hold_cs[N];

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!s_oe[k]) oe_run[k]++;
      else if (oe_run[k] != 0) begin
        last_oe_w[k] = oe_run[k];
        n_oe[k]++;
        oe_run[k] = 0;
      end
      if (!s_we[k]) we_run[k]++;
      else if (we_run[k] != 0) begin
        last_we_w[k] = we_run[k];
        n_we[k]++;
        we_run[k]  = 0;
        hold_d[k]  = sd_all[k*8 +: 8];
        hold_cs[k] = s_cs[k];
        if (!s_cs[k]) begin
          mem[k][s_a_all[k*19 +: 19]] = hold_d[k];
          wf[k][s_a_all[k*19 +: 19]]  = 1'b1;
        end
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference contents as seen from the ARM: last value written, else background.
  logic [7:0] model [int];

  function automatic logic [7:0] model_rd(input int k, input logic [18:0] a);
    int key;
    key = k * MEMD + int'(a);
    return model.exists(key) ? model[key] : bg(a);
  endfunction

  task automatic do_access(input int k, input bit wr, input bit ill, input logic [18:0] a,
                           input logic [7:0] d, input logic [7:0] exp_d,
                           input int exp_lat, input int exp_w);
    int lat;
    int noe0;
    int nwe0;
    noe0 = n_oe[k];
    nwe0 = n_we[k];
    @(posedge clk); #1;
    arm_a     = a;
    arm_oe    = wr;
    arm_we    = !(wr || ill);
    arm_drv   = wr;
    arm_dout  = d;
    arm_cs[k] = 1'b0;
    #1;
    chk("nwait_assert", 32'(nwait[k]), 0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (nwait[k]) break;
    end
    chk("latency", lat, exp_lat);
    if (!wr) chk("arm_rdata", 32'(arm_d), 32'(exp_d));
    @(posedge clk); #1;
    arm_cs  = '1;
    arm_oe  = 1'b1;
    arm_we  = 1'b1;
    arm_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("arm_d_hiz", 32'(arm_d), 32'hFF);
    chk("sram_d_idle", 32'(sd_all[k*8 +: 8]), 32'hFF);
    if (wr) begin
      chk("we_width", last_we_w[k], exp_w);
      chk("we_count", n_we[k] - nwe0, 1);
      chk("oe_count_wr", n_oe[k] - noe0, 0);
      chk("wr_hold_data", 32'(hold_d[k]), 32'(d));
      chk("wr_hold_cs", 32'(hold_cs[k]), 0);
      chk("sram_mem", 32'(mem[k][a]), 32'(d));
    end else begin
      chk("oe_width", last_oe_w[k], exp_w);
      chk("oe_count", n_oe[k] - noe0, 1);
      chk("we_count_rd", n_we[k] - nwe0, 0);
    end
  endtask

  typedef struct {
    int          k;
    bit          wr;
    bit          ill;
    logic [18:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_d;
    int          exp_lat;
    int          exp_w;
  } vec_t;

  vec_t vt[10];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nwe0;
    int          noe0;
    int          wd;
    int          k;
    bit          wr;
    bit          ill;
    logic [18:0] a;
    logic [7:0]  d;
    logic [18:0] pool[6];

    vt[0] = '{0, 1'b0, 1'b0, 19'h12345, 8'h00, 8'hA5,  6, 3};
    vt[1] = '{0, 1'b1, 1'b0, 19'h7FFFF, 8'h3C, 8'h00,  5, 1};
    vt[2] = '{0, 1'b0, 1'b0, 19'h7FFFF, 8'h00, 8'h3C,  6, 3};
    vt[3] = '{1, 1'b1, 1'b0, 19'h00000, 8'h5A, 8'h00,  6, 2};
    vt[4] = '{1, 1'b0, 1'b0, 19'h00000, 8'h00, 8'h5A,  4, 1};
    vt[5] = '{2, 1'b1, 1'b0, 19'h2AAAA, 8'hC3, 8'h00, 10, 6};
    vt[6] = '{2, 1'b0, 1'b0, 19'h2AAAA, 8'h00, 8'hC3,  5, 2};
    vt[7] = '{3, 1'b1, 1'b0, 19'h15555, 8'h96, 8'h00,  8, 4};
    vt[8] = '{3, 1'b0, 1'b0, 19'h15555, 8'h00, 8'h96,  9, 6};
    vt[9] = '{1, 1'b0, 1'b1, 19'h00000, 8'h00, 8'h5A,  4, 1};

    arm_cs   = '1;
    arm_oe   = 1'b1;
    arm_we   = 1'b1;
    arm_drv  = 1'b0;
    arm_a    = '0;
    arm_dout = '0;

    // Reset state, including an ARM read attempt while reset is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sram_cs", 32'(s_cs), 32'hF);
    chk("rst_sram_oe", 32'(s_oe), 32'hF);
    chk("rst_sram_we", 32'(s_we), 32'hF);
    chk("rst_sram_a", s_a_all[31:0], 0);
    chk("rst_sram_d", sd_all, 32'hFFFF_FFFF);
    chk("rst_nwait", 32'(nwait), 32'hF);
    arm_cs[0] = 1'b0;
    arm_oe    = 1'b0;
    #1;
    chk("rst_nwait_cs_low", 32'(nwait[0]), 1);
    chk("rst_arm_d_hiz", 32'(arm_d), 32'hFF);
    arm_cs = '1;
    arm_oe = 1'b1;
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Directed vectors, including the illegal OE+WE case in the last row.
    for (int i = 0; i < 10; i++) begin
      do_access(vt[i].k, vt[i].wr, vt[i].ill, vt[i].a, vt[i].d, vt[i].exp_d, vt[i].exp_lat, vt[i].exp_w);
      if (vt[i].wr) model[vt[i].k * MEMD + int'(vt[i].a)] = vt[i].d;
    end

    // Abort one cycle into a WR_WS=3 write: the WE pulse still runs 4 cycles.
    nwe0 = n_we[3];
    noe0 = n_oe[3];
    @(posedge clk); #1;
    arm_a     = 19'h0ABCD;
    arm_oe    = 1'b1;
    arm_we    = 1'b0;
    arm_drv   = 1'b1;
    arm_dout  = 8'h77;
    arm_cs[3] = 1'b0;
    wd = 0;
    while (wd < 20) begin
      @(posedge clk); #1;
      wd++;
      if (!s_we[3]) break;
    end
    chk("abort_we_start", 32'(s_we[3]), 0);
    @(posedge clk); #1;
    arm_cs[3] = 1'b1;
    arm_we    = 1'b1;
    arm_drv   = 1'b0;
    #1;
    chk("abort_nwait", 32'(nwait[3]), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_we_width", last_we_w[3], 4);
    chk("abort_we_count", n_we[3] - nwe0, 1);
    chk("abort_oe_count", n_oe[3] - noe0, 0);
    chk("abort_mem", 32'(mem[3][19'h0ABCD]), 32'h77);
    chk("abort_idle_cs", 32'(s_cs[3]), 1);
    model[3 * MEMD + 32'h0ABCD] = 8'h77;
    do_access(3, 1'b0, 1'b0, 19'h0ABCD, 8'h00, 8'h77, 9, 6);

    // Reset asserted in the middle of a write.
    @(posedge clk); #1;
    arm_a     = 19'h01234;
    arm_we    = 1'b0;
    arm_drv   = 1'b1;
    arm_dout  = 8'hEE;
    arm_cs[3] = 1'b0;
    wd = 0;
    while (wd < 20) begin
      @(posedge clk); #1;
      wd++;
      if (!s_we[3]) break;
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_we", 32'(s_we[3]), 1);
    chk("midrst_cs", 32'(s_cs[3]), 1);
    chk("midrst_oe", 32'(s_oe[3]), 1);
    chk("midrst_sram_d", 32'(sd_all[31:24]), 32'hFF);
    chk("midrst_nwait", 32'(nwait[3]), 1);
    repeat (2) @(posedge clk);
    #1;
    arm_cs  = '1;
    arm_we  = 1'b1;
    arm_drv = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Randomised accesses against the reference contents.
    for (int i = 0; i < 6; i++) pool[i] = 19'($urandom);
    for (int i = 0; i < 36; i++) begin
      k   = int'($urandom_range(0, N - 1));
      wr  = 1'($urandom_range(0, 1));
      ill = (!wr) && ($urandom_range(0, 5) == 0);
      a   = pool[$urandom_range(0, 5)];
      d   = 8'($urandom);
      if (wr) begin
        do_access(k, 1'b1, 1'b0, a, d, 8'h00, SYNC + 1 + wrw(k) + 2, wrw(k) + 1);
        model[k * MEMD + int'(a)] = d;
      end else begin
        do_access(k, 1'b0, ill, a, 8'h00, model_rd(k, a), SYNC + 1 + rdw(k) + 1, rdw(k) + 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
